box_step_scheduler: RTL and testbench

Time-multiplexes one shared box-bounce step datapath across up to `NUM_BOX` independent 5x5 boxes on the 96x64 OLED. It holds each box's top-left position, velocity and active flag. On every frame tick it issues one step request per active box to the external step unit and writes the returned position and velocity back. A combinational read port feeds the renderer.

---
 rtl/oled_pkg.sv | 29 ++
 rtl/box_state_regfile.sv | 46 ++++
 rtl/box_step_scheduler.sv | 170 +++++++++++++++++
 tb/tb_box_step_scheduler.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oled_pkg.sv
// Shared OLED box-animation types: screen limits, box state record and
// scheduler state encoding.
package oled_pkg;

    localparam int MAX_X    = 95;
    localparam int MAX_Y    = 63;
    localparam int BOX_SIZE = 4;

    localparam int POS_W = 9;
    localparam int VEL_W = 13;

    typedef struct packed {
        logic [POS_W-1:0]        x;
        logic [POS_W-1:0]        y;
        logic signed [VEL_W-1:0] vx;
        logic signed [VEL_W-1:0] vy;
        logic                    active;
    } box_state_t;

    localparam int BOX_W = $bits(box_state_t);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_NEXT
    } sched_state_t;

endpackage

// File: rtl/box_state_regfile.sv
// Per-box state storage: config and write-back write ports, plus an operand
// read port and a renderer read port, both combinational.
module box_state_regfile
    import oled_pkg::*;
#(
    parameter int NUM_BOX = 4,
    localparam int IDX_W = $clog2(NUM_BOX)
) (
    input  logic             slow_clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic [BOX_W-1:0] cfg_data,
    input  logic             wb_we,
    input  logic [IDX_W-1:0] wb_idx,
    input  logic [BOX_W-1:0] wb_data,
    input  logic [IDX_W-1:0] op_idx,
    output logic [BOX_W-1:0] op_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [POS_W-1:0] rd_x,
    output logic [POS_W-1:0] rd_y,
    output logic             rd_active
);

    box_state_t slots [NUM_BOX];

    // Config writes only happen in IDLE and write-backs only in WAIT, so the
    // two ports never target the same cycle.
    always_ff @(posedge slow_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BOX; i++) begin
                slots[i] <= '0;
            end
        end else if (cfg_we) begin
            slots[cfg_idx] <= box_state_t'(cfg_data);
        end else if (wb_we) begin
            slots[wb_idx] <= box_state_t'(wb_data);
        end
    end

    assign op_data   = slots[op_idx];
    assign rd_x      = slots[rd_idx].x;
    assign rd_y      = slots[rd_idx].y;
    assign rd_active = slots[rd_idx].active;

endmodule

// File: rtl/box_step_scheduler.sv
// Time-multiplexes one external box-step unit across NUM_BOX box slots,
// stepping every active slot once per frame tick.
module box_step_scheduler
    import oled_pkg::*;
#(
    parameter int NUM_BOX  = 4,
    parameter int TICK_DIV = 8,
    parameter int TIMEOUT  = 15,
    localparam int IDX_W = $clog2(NUM_BOX)
) (
    input  logic                    slow_clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [IDX_W-1:0]        cfg_idx,
    input  logic [POS_W-1:0]        cfg_x,
    input  logic [POS_W-1:0]        cfg_y,
    input  logic signed [VEL_W-1:0] cfg_vx,
    input  logic signed [VEL_W-1:0] cfg_vy,
    input  logic                    cfg_active,
    output logic                    step_start,
    output logic [POS_W-1:0]        step_x,
    output logic [POS_W-1:0]        step_y,
    output logic signed [VEL_W-1:0] step_vx,
    output logic signed [VEL_W-1:0] step_vy,
    input  logic                    step_done,
    input  logic [POS_W-1:0]        res_x,
    input  logic [POS_W-1:0]        res_y,
    input  logic signed [VEL_W-1:0] res_vx,
    input  logic signed [VEL_W-1:0] res_vy,
    input  logic [IDX_W-1:0]        rd_idx,
    output logic [POS_W-1:0]        rd_x,
    output logic [POS_W-1:0]        rd_y,
    output logic                    rd_active,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    err_overrun,
    output logic                    err_timeout
);

    localparam int TCNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int WCNT_W = $clog2(TIMEOUT + 1);
    localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(TICK_DIV - 1);
    localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_BOX - 1);

    sched_state_t      state, state_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt;
    logic [TCNT_W-1:0] tick_cnt;
    logic [WCNT_W-1:0] wait_cnt;
    logic              tick, timeout_hit, cfg_we, wb_we;
    box_state_t        cfg_data, wb_data, op_data;

    assign tick        = enable && (tick_cnt == TCNT_MAX);
    assign timeout_hit = (state == S_WAIT) && !step_done && (wait_cnt == WCNT_MAX);
    assign cfg_data    = '{x: cfg_x, y: cfg_y, vx: cfg_vx, vy: cfg_vy, active: cfg_active};
    assign wb_data     = '{x: res_x, y: res_y, vx: res_vx, vy: res_vy, active: 1'b1};

    always_ff @(posedge slow_clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (enable) begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge slow_clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            idx      <= '0;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            wait_cnt <= (state == S_WAIT && state_nxt == S_WAIT) ? wait_cnt + 1'b1 : '0;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            S_IDLE: begin
                if (tick) begin
                    state_nxt = S_ISSUE;
                    idx_nxt   = '0;
                end
            end
            S_ISSUE: state_nxt = step_start ? S_WAIT : S_NEXT;
            S_WAIT: begin
                if (step_done || timeout_hit) begin
                    state_nxt = S_NEXT;
                end
            end
            S_NEXT: begin
                if (idx == IDX_LAST) begin
                    state_nxt = S_IDLE;
                end else begin
                    state_nxt = S_ISSUE;
                    idx_nxt   = idx + 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != S_IDLE);
        cfg_ready  = (state == S_IDLE) && !tick;
        frame_done = (state == S_NEXT) && (idx == IDX_LAST);
        cfg_we     = cfg_valid && cfg_ready;
        wb_we      = (state == S_WAIT) && step_done;
    end

    // Operands are read at the slot about to enter ISSUE so the request pulse
    // and its operands appear registered in the ISSUE cycle itself.
    always_ff @(posedge slow_clk or negedge rst_n) begin
        if (!rst_n) begin
            step_start <= 1'b0;
            step_x     <= '0;
            step_y     <= '0;
            step_vx    <= '0;
            step_vy    <= '0;
        end else begin
            step_start <= 1'b0;
            if (state_nxt == S_ISSUE && op_data.active) begin
                step_start <= 1'b1;
                step_x     <= op_data.x;
                step_y     <= op_data.y;
                step_vx    <= op_data.vx;
                step_vy    <= op_data.vy;
            end
        end
    end

    always_ff @(posedge slow_clk or negedge rst_n) begin
        if (!rst_n) begin
            err_overrun <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            if (tick && state != S_IDLE) begin
                err_overrun <= 1'b1;
            end
            if (timeout_hit) begin
                err_timeout <= 1'b1;
            end
        end
    end

    box_state_regfile #(
        .NUM_BOX(NUM_BOX)
    ) u_regfile (
        .slow_clk (slow_clk),
        .rst_n    (rst_n),
        .cfg_we   (cfg_we),
        .cfg_idx  (cfg_idx),
        .cfg_data (cfg_data),
        .wb_we    (wb_we),
        .wb_idx   (idx),
        .wb_data  (wb_data),
        .op_idx   (idx_nxt),
        .op_data  (op_data),
        .rd_idx   (rd_idx),
        .rd_x     (rd_x),
        .rd_y     (rd_y),
        .rd_active(rd_active)
    );

endmodule

// File: tb/tb_box_step_scheduler.sv
// Self-checking bench for box_step_scheduler: config table, step-unit model
// with request scoreboard, and hand-written frame/timeout/overrun/reset cases.
module tb_box_step_scheduler;
    import oled_pkg::*;

    localparam int NUM_BOX  = 4;
    localparam int TICK_DIV = 8;
    localparam int TIMEOUT  = 15;
    localparam int IDX_W    = $clog2(NUM_BOX);

    logic                    slow_clk = 1'b0;
    logic                    rst_n;
    logic                    enable;
    logic                    cfg_valid;
    logic                    cfg_ready;
    logic [IDX_W-1:0]        cfg_idx;
    logic [POS_W-1:0]        cfg_x, cfg_y;
    logic signed [VEL_W-1:0] cfg_vx, cfg_vy;
    logic                    cfg_active;
    logic                    step_start;
    logic [POS_W-1:0]        step_x, step_y;
    logic signed [VEL_W-1:0] step_vx, step_vy;
    logic                    step_done;
    logic [POS_W-1:0]        res_x, res_y;
    logic signed [VEL_W-1:0] res_vx, res_vy;
    logic [IDX_W-1:0]        rd_idx;
    logic [POS_W-1:0]        rd_x, rd_y;
    logic                    rd_active;
    logic                    busy, frame_done, err_overrun, err_timeout;

    typedef struct {
        int x;
        int y;
        int vx;
        int vy;
    } req_t;

    typedef struct {
        bit valid;
        int idx;
        int x;
        int y;
        int vx;
        int vy;
        bit active;
        int exp_x;
        int exp_y;
        bit exp_active;
    } cfg_vec_t;

    req_t exp_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   cyc       = 0;
    int   fd_cnt    = 0;
    int   lat       = 1;
    bit   hang_next = 1'b0;

    box_step_scheduler #(
        .NUM_BOX (NUM_BOX),
        .TICK_DIV(TICK_DIV),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .slow_clk   (slow_clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_idx    (cfg_idx),
        .cfg_x      (cfg_x),
        .cfg_y      (cfg_y),
        .cfg_vx     (cfg_vx),
        .cfg_vy     (cfg_vy),
        .cfg_active (cfg_active),
        .step_start (step_start),
        .step_x     (step_x),
        .step_y     (step_y),
        .step_vx    (step_vx),
        .step_vy    (step_vy),
        .step_done  (step_done),
        .res_x      (res_x),
        .res_y      (res_y),
        .res_vx     (res_vx),
        .res_vy     (res_vy),
        .rd_idx     (rd_idx),
        .rd_x       (rd_x),
        .rd_y       (rd_y),
        .rd_active  (rd_active),
        .busy       (busy),
        .frame_done (frame_done),
        .err_overrun(err_overrun),
        .err_timeout(err_timeout)
    );

    always #5 slow_clk = ~slow_clk;

    always @(posedge slow_clk) cyc++;

    task automatic checkOutput(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pushReq(input int x, input int y, input int vx, input int vy);
        req_t r;
        r.x  = x;
        r.y  = y;
        r.vx = vx;
        r.vy = vy;
        exp_q.push_back(r);
    endtask

    // Step-unit model: answers lat cycles after the request with position += velocity.
    logic [POS_W-1:0]        mx, my;
    logic signed [VEL_W-1:0] mvx, mvy;
    int                      pend = 0;

    always @(negedge slow_clk) begin
        step_done = 1'b0;
        if (!rst_n) begin
            pend = 0;
        end else if (step_start) begin
            if (hang_next) begin
                hang_next = 1'b0;
                pend      = 0;
            end else begin
                pend = lat;
                mx   = step_x;
                my   = step_y;
                mvx  = step_vx;
                mvy  = step_vy;
            end
        end else if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                step_done = 1'b1;
                res_x     = mx + mvx[POS_W-1:0];
                res_y     = my + mvy[POS_W-1:0];
                res_vx    = mvx;
                res_vy    = mvy;
            end
        end
    end

    // Scoreboard: every request pulse must match the next expected operand set.
    always @(negedge slow_clk) begin
        req_t r;
        if (rst_n) begin
            if (frame_done) fd_cnt++;
            if (step_start) begin
                checkOutput("step_start_expected", (exp_q.size() > 0) ? 1 : 0, 1);
                if (exp_q.size() > 0) begin
                    r = exp_q.pop_front();
                    checkOutput("req_x", int'(step_x), r.x);
                    checkOutput("req_y", int'(step_y), r.y);
                    checkOutput("req_vx", int'(step_vx), r.vx);
                    checkOutput("req_vy", int'(step_vy), r.vy);
                end
            end
        end
    end

    task automatic doReset();
        rst_n      = 1'b0;
        enable     = 1'b0;
        cfg_valid  = 1'b0;
        cfg_idx    = '0;
        cfg_x      = '0;
        cfg_y      = '0;
        cfg_vx     = '0;
        cfg_vy     = '0;
        cfg_active = 1'b0;
        rd_idx     = '0;
        res_x      = '0;
        res_y      = '0;
        res_vx     = '0;
        res_vy     = '0;
        hang_next  = 1'b0;
        lat        = 1;
        exp_q.delete();
        repeat (2) @(negedge slow_clk);
        rst_n = 1'b1;
        @(negedge slow_clk);
    endtask

    task automatic applyStimulus(input bit valid, input int idx, input int x, input int y,
                                 input int vx, input int vy, input bit act);
        cfg_valid  = valid;
        cfg_idx    = IDX_W'(idx);
        cfg_x      = POS_W'(x);
        cfg_y      = POS_W'(y);
        cfg_vx     = VEL_W'(vx);
        cfg_vy     = VEL_W'(vy);
        cfg_active = act;
        @(negedge slow_clk);
        cfg_valid = 1'b0;
    endtask

    task automatic checkSlot(input string name, input int idx, input int ex, input int ey,
                             input int ea);
        rd_idx = IDX_W'(idx);
        #1;
        checkOutput({name, "_x"}, int'(rd_x), ex);
        checkOutput({name, "_y"}, int'(rd_y), ey);
        checkOutput({name, "_active"}, int'(rd_active), ea);
    endtask

    task automatic runFrame(input int exp_len, input bit hold_en, input string name);
        bit seen;
        int c1;
        enable = 1'b1;
        seen   = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge slow_clk);
            if (busy) seen = 1'b1;
        end
        checkOutput({name, "_started"}, int'(seen), 1);
        if (!hold_en) enable = 1'b0;
        c1   = cyc;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (frame_done) seen = 1'b1;
            else @(negedge slow_clk);
        end
        checkOutput({name, "_done"}, int'(seen), 1);
        checkOutput({name, "_latency"}, cyc - c1 + 1, exp_len);
        enable = 1'b0;
        @(negedge slow_clk);
        checkOutput({name, "_idle_after"}, int'(busy), 0);
        checkOutput({name, "_sb_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        cfg_vec_t vecs[6];
        bit       seen;
        bit       stall_ok;
        int       fd0;

        vecs[0] = '{1'b1, 0, 10, 20, 2, -1, 1'b1, 10, 20, 1'b1};
        vecs[1] = '{1'b1, 1, 511, 63, -4096, 4095, 1'b0, 511, 63, 1'b0};
        vecs[2] = '{1'b1, 3, 95, 0, 7, -7, 1'b1, 95, 0, 1'b1};
        vecs[3] = '{1'b0, 0, 1, 2, 3, 4, 1'b0, 10, 20, 1'b1};
        vecs[4] = '{1'b1, 1, 0, 511, 0, 0, 1'b1, 0, 511, 1'b1};
        vecs[5] = '{1'b1, 2, 33, 44, -1, -1, 1'b0, 33, 44, 1'b0};

        doReset();
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_cfg_ready", int'(cfg_ready), 1);
        checkOutput("reset_err_overrun", int'(err_overrun), 0);
        checkOutput("reset_err_timeout", int'(err_timeout), 0);
        checkOutput("reset_step_start", int'(step_start), 0);
        for (int s = 0; s < NUM_BOX; s++) checkSlot($sformatf("reset_slot%0d", s), s, 0, 0, 0);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].valid, vecs[i].idx, vecs[i].x, vecs[i].y,
                          vecs[i].vx, vecs[i].vy, vecs[i].active);
            checkSlot($sformatf("cfg_vec%0d", i), vecs[i].idx, vecs[i].exp_x,
                      vecs[i].exp_y, int'(vecs[i].exp_active));
        end

        // Single active slot, two consecutive frames (second frame shows stored velocity).
        doReset();
        applyStimulus(1'b1, 0, 10, 20, 2, -1, 1'b1);
        pushReq(10, 20, 2, -1);
        runFrame(3 + 2 + 2 + 2, 1'b0, "frame_single");
        checkSlot("single_slot0", 0, 12, 19, 1);
        checkSlot("single_slot1", 1, 0, 0, 0);
        pushReq(12, 19, 2, -1);
        runFrame(9, 1'b0, "frame_single2");
        checkSlot("single2_slot0", 0, 14, 18, 1);

        // Slots 1 and 3 active only.
        doReset();
        applyStimulus(1'b1, 0, 7, 7, 1, 1, 1'b0);
        applyStimulus(1'b1, 1, 40, 30, -5, 3, 1'b1);
        applyStimulus(1'b1, 2, 9, 9, 1, 1, 1'b0);
        applyStimulus(1'b1, 3, 80, 60, 1, 1, 1'b1);
        pushReq(40, 30, -5, 3);
        pushReq(80, 60, 1, 1);
        runFrame(2 + 3 + 2 + 3, 1'b0, "frame_sparse");
        checkSlot("sparse_slot0", 0, 7, 7, 0);
        checkSlot("sparse_slot1", 1, 35, 33, 1);
        checkSlot("sparse_slot2", 2, 9, 9, 0);
        checkSlot("sparse_slot3", 3, 81, 61, 1);
        checkOutput("sparse_err_overrun", int'(err_overrun), 0);

        // Step unit never answers slot 0: abort after TIMEOUT, slot 1 still stepped.
        doReset();
        applyStimulus(1'b1, 0, 50, 40, 3, 3, 1'b1);
        applyStimulus(1'b1, 1, 20, 20, 1, 2, 1'b1);
        hang_next = 1'b1;
        pushReq(50, 40, 3, 3);
        pushReq(20, 20, 1, 2);
        checkOutput("timeout_flag_before", int'(err_timeout), 0);
        runFrame((2 + TIMEOUT) + 3 + 2 + 2, 1'b0, "frame_timeout");
        checkOutput("timeout_flag_after", int'(err_timeout), 1);
        checkSlot("timeout_slot0", 0, 50, 40, 1);
        checkSlot("timeout_slot1", 1, 21, 22, 1);
        checkOutput("timeout_err_overrun", int'(err_overrun), 0);

        // Four active slots at L=3 give a 20-cycle frame: ticks inside it are dropped.
        doReset();
        lat = 3;
        applyStimulus(1'b1, 0, 10, 10, 1, 1, 1'b1);
        applyStimulus(1'b1, 1, 20, 20, 1, 1, 1'b1);
        applyStimulus(1'b1, 2, 30, 30, -1, -1, 1'b1);
        applyStimulus(1'b1, 3, 40, 40, 2, 2, 1'b1);
        pushReq(10, 10, 1, 1);
        pushReq(20, 20, 1, 1);
        pushReq(30, 30, -1, -1);
        pushReq(40, 40, 2, 2);
        fd0 = fd_cnt;
        runFrame(20, 1'b1, "frame_overrun");
        checkOutput("overrun_flag", int'(err_overrun), 1);
        repeat (10) @(negedge slow_clk);
        checkOutput("overrun_frame_done_count", fd_cnt - fd0, 1);
        checkSlot("overrun_slot2", 2, 29, 29, 1);
        checkSlot("overrun_slot3", 3, 42, 42, 1);

        // Config write raised on the tick cycle and held through the frame.
        doReset();
        applyStimulus(1'b1, 0, 10, 10, 1, 1, 1'b1);
        pushReq(10, 10, 1, 1);
        enable = 1'b1;
        repeat (TICK_DIV - 1) @(negedge slow_clk);
        checkOutput("cfg_ready_on_tick", int'(cfg_ready), 0);
        cfg_valid  = 1'b1;
        cfg_idx    = '0;
        cfg_x      = 9'd60;
        cfg_y      = 9'd30;
        cfg_vx     = '0;
        cfg_vy     = '0;
        cfg_active = 1'b1;
        @(negedge slow_clk);
        checkOutput("stall_busy_after_tick", int'(busy), 1);
        enable   = 1'b0;
        stall_ok = 1'b1;
        seen     = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            if (cfg_ready) stall_ok = 1'b0;
            if (frame_done) seen = 1'b1;
            else @(negedge slow_clk);
        end
        checkOutput("stall_frame_done", int'(seen), 1);
        checkOutput("stall_cfg_ready_low", int'(stall_ok), 1);
        checkSlot("stall_wb_only", 0, 11, 11, 1);
        @(negedge slow_clk);
        checkOutput("stall_cfg_ready_idle", int'(cfg_ready), 1);
        @(negedge slow_clk);
        cfg_valid = 1'b0;
        checkSlot("stall_cfg_written", 0, 60, 30, 1);

        // Asynchronous reset while a step is outstanding.
        doReset();
        applyStimulus(1'b1, 0, 5, 5, 1, 1, 1'b1);
        applyStimulus(1'b1, 2, 6, 6, 1, 1, 1'b1);
        hang_next = 1'b1;
        pushReq(5, 5, 1, 1);
        enable = 1'b1;
        seen   = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge slow_clk);
            if (busy) seen = 1'b1;
        end
        enable = 1'b0;
        repeat (4) @(negedge slow_clk);
        checkOutput("midwait_busy", int'(busy), 1);
        checkOutput("midwait_sb_empty", exp_q.size(), 0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midwait_rst_busy", int'(busy), 0);
        checkOutput("midwait_rst_cfg_ready", int'(cfg_ready), 1);
        checkOutput("midwait_rst_err_timeout", int'(err_timeout), 0);
        checkOutput("midwait_rst_err_overrun", int'(err_overrun), 0);
        for (int s = 0; s < NUM_BOX; s++) begin
            rd_idx = IDX_W'(s);
            #1;
            checkOutput($sformatf("midwait_rst_active%0d", s), int'(rd_active), 0);
        end
        @(negedge slow_clk);
        rst_n = 1'b1;
        repeat (TIMEOUT + 4) @(negedge slow_clk);
        checkOutput("midwait_post_err_timeout", int'(err_timeout), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
